// File: rtl/hazard_stall_ctrl.sv
// hazard_stall_ctrl: decides each cycle whether the D-stage instruction may
// advance. It stalls on RAW hazards that forwarding cannot cover (Tuse/Tnew
// against E and M) and on mult/div accesses while the multi-cycle unit is busy.
// A stall holds PC and IF/ID and turns ID/EX into a bubble. A saturating counter
// records how many cycles were stalled.
module hazard_stall_ctrl #(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10,
    parameter int CNT_W       = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [4:0]       d_rs,
    input  logic [4:0]       d_rt,
    input  logic [1:0]       d_tuse_rs,
    input  logic [1:0]       d_tuse_rt,
    input  logic             d_is_md,
    input  logic [4:0]       e_wreg,
    input  logic [1:0]       e_tnew,
    input  logic [4:0]       m_wreg,
    input  logic [1:0]       m_tnew,
    input  logic             md_start,
    input  logic             md_is_div,
    output logic             pc_en,
    output logic             if_id_en,
    output logic             id_ex_clr,
    output logic             md_busy,
    output logic [CNT_W-1:0] stall_cnt
);

    localparam int MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int BW         = $clog2(MAX_CYCLES + 1);

    localparam logic [BW-1:0]    MULT_LOAD = BW'(MULT_CYCLES);
    localparam logic [BW-1:0]    DIV_LOAD  = BW'(DIV_CYCLES);
    localparam logic [BW-1:0]    CNT_ONE   = BW'(1);
    localparam logic [CNT_W-1:0] STALL_MAX = {CNT_W{1'b1}};

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } md_state_e;

    md_state_e        state_q, state_d;
    logic [BW-1:0]    md_cnt_q, md_cnt_d;
    logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;

    logic stall_rs, stall_rt, md_stall, stall;

    // State register: FSM state, busy down-counter and stall performance counter.
    // NOTE: sequential state uses non-blocking assignments so every flop samples
    // pre-edge values regardless of statement order.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            md_cnt_q    <= '0;
            stall_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            md_cnt_q    <= md_cnt_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

    // Next-state logic: load the busy count on a start from IDLE, count down in BUSY.
    // A start seen while BUSY is deliberately ignored (no reload).
    // NOTE: every comb output gets a default first so no path can infer a latch.
    always_comb begin
        state_d  = state_q;
        md_cnt_d = md_cnt_q;
        unique case (state_q)
            IDLE: begin
                if (md_start) begin
                    md_cnt_d = md_is_div ? DIV_LOAD : MULT_LOAD;
                    state_d  = BUSY;
                end
            end
            BUSY: begin
                md_cnt_d = md_cnt_q - CNT_ONE;
                if (md_cnt_q == CNT_ONE) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d  = IDLE;
                md_cnt_d = '0;
            end
        endcase
    end

    // FSM outputs: busy is a pure decode of the registered state.
    always_comb begin
        md_busy = (state_q == BUSY);
    end

    // Hazard detection: register 0 never stalls; Tuse==3 means the operand is unused.
    always_comb begin
        stall_rs = (d_rs != 5'd0) && (d_tuse_rs != 2'd3) &&
                   (((d_rs == e_wreg) && (e_tnew > d_tuse_rs)) ||
                    ((d_rs == m_wreg) && (m_tnew > d_tuse_rs)));
        stall_rt = (d_rt != 5'd0) && (d_tuse_rt != 2'd3) &&
                   (((d_rt == e_wreg) && (e_tnew > d_tuse_rt)) ||
                    ((d_rt == m_wreg) && (m_tnew > d_tuse_rt)));
        md_stall = d_is_md && (md_busy || md_start);
        stall    = stall_rs || stall_rt || md_stall;
    end

    // Stall counter next value: one per stalled cycle, holding at all-ones.
    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if (stall && (stall_cnt_q != STALL_MAX)) begin
            stall_cnt_d = stall_cnt_q + CNT_W'(1);
        end
    end

    // Pipeline register controls.
    always_comb begin
        pc_en     = ~stall;
        if_id_en  = ~stall;
        id_ex_clr = stall;
        stall_cnt = stall_cnt_q;
    end

endmodule
